seq_detect_1101: RTL and testbench
==================================

// Module: seq_detect_1101
// PURPOSE
//  Consumer of the debounced button strobes (load, clock) from the xiaodou debouncer.
//  On a load strobe, captures a WIDTH-bit switch word. On each clock strobe, shifts one bit
//  out, MSB first, into a Moore FSM that detects the pattern 1101 (overlapping) and counts matches.
//  Drives the LEDs / 7-seg of the sequence-detector lab board.
// PARAMETERS
//  WIDTH  8  bits in the serial word; 2..16
//  CNT_W  4  match counter width; counter saturates
// PORTS
//  clk        in   1        system clock; all logic on posedge
//  reset      in   1        synchronous, active-high
//  load_in    in   1        debounced load level; rising edge starts a frame
//  clock_in   in   1        debounced shift level; rising edge shifts one bit
//  data_in    in   WIDTH    parallel word, sampled on load rising edge
//  cur_bit    out  1        bit consumed by the most recent shift
//  bit_idx    out  5        number of bits shifted in this frame, 0..WIDTH
//  state      out  3        FSM state code S0..S4 = 0..4
//  detected   out  1        Moore output: 1 iff state==S4
//  match_cnt  out  CNT_W    1101 matches in this frame, saturating
//  busy       out  1        frame in progress
//  done       out  1        all WIDTH bits shifted; held until next load or reset
// BEHAVIOUR
//  Reset: all outputs 0, state=S0, shreg=0, load_q=clock_q=0.
//  - An input held high through reset therefore yields one rise on the first cycle after reset.
//  Edge detect: x_q <= x each clk; rise = x & ~x_q; act on the same edge that samples the rise.
//  load rise (any time, even mid-frame): shreg<=data_in, bit_idx<=0, state<=S0, match_cnt<=0,
//  cur_bit<=0, busy<=1, done<=0.
//  clock rise with busy=1 and no load rise: b=shreg[WIDTH-1]; shreg<=shreg<<1; cur_bit<=b;
//  bit_idx++; state<=next(state,b).
//  - If the new state is S4, match_cnt++ (saturates at 2^CNT_W-1).
//  - If bit_idx was WIDTH-1: busy<=0, done<=1.
//  clock rise with busy=0: ignored; no output changes.
//  Simultaneous load and clock rise: load wins; the shift is dropped.
//  FSM (Moore; next state for input 0 / 1):
//   S0 none  : 0->S0 1->S1
//   S1 "1"   : 0->S0 1->S2
//   S2 "11"  : 0->S3 1->S2
//   S3 "110" : 0->S0 1->S4
//   S4 "1101": 0->S0 1->S2  (overlap)
//  detected is a registered state decode: high from the edge after the clock-rise sample.
//  - Held through done until the next load or reset.
//  Latency: clock_in high at edge k -> cur_bit/state/detected/match_cnt valid after edge k.
//  Reset mid-frame: frame abandoned; all outputs return to reset values.
// TESTING
//  1 reset=1 with load_in=clock_in=0, then release -> all outputs 0, state=0, no activity.
//  2 load with data_in=8'b11011010, then 8 clock rises -> states 1,2,3,4,2,3,4,0;
//    detected high after shifts 4 and 7; match_cnt=2, done=1, busy=0.
//  3 data_in=8'hFF, 8 shifts -> state stays 2 from the 2nd shift; match_cnt=0; done=1.
//  4 data_in=8'b01101101, 8 shifts -> S4 after shifts 5 and 8; detected=1 held after done;
//    match_cnt=2.
//  5 2 extra clock rises after done -> no change. Then load and clock rise on the same
//    cycle -> bit_idx=0, busy=1, state=0.
//  6 reset after 3 shifts -> all zeros. load_in held high through reset ->
//    one frame start on the cycle after release.

Source files
------------

// File: rtl/seq_detect_1101.sv
// seq_detect_1101
// Serial 1101 pattern detector for the sequence-detector lab board.
// A rising edge on load_in captures a WIDTH-bit word; each rising edge on
// clock_in (while a frame is in progress) shifts one bit out, MSB first, into
// a Moore FSM that recognises 1101 with overlap and counts matches.
//
// Ports
//   clk        in   1      system clock, all logic on posedge
//   reset      in   1      synchronous, active-high
//   load_in    in   1      debounced load level; rising edge starts a frame
//   clock_in   in   1      debounced shift level; rising edge shifts one bit
//   data_in    in   WIDTH  parallel word, sampled on load rising edge
//   cur_bit    out  1      bit consumed by the most recent shift
//   bit_idx    out  5      bits shifted in this frame, 0..WIDTH
//   state      out  3      FSM state code S0..S4 = 0..4
//   detected   out  1      1 iff state == S4 (registered decode)
//   match_cnt  out  CNT_W  1101 matches in this frame, saturating
//   busy       out  1      frame in progress
//   done       out  1      all WIDTH bits shifted; held until load or reset
module seq_detect_1101 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_in,
    input  logic             clock_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             cur_bit,
    output logic [4:0]       bit_idx,
    output logic [2:0]       state,
    output logic             detected,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [4:0]       LAST_IDX = 5'(WIDTH - 1);

    // Overlapping 1101 transition table; S4 on a 1 falls back to "11".
    function automatic state_t fsm_next(input state_t cur, input logic b);
        state_t nxt;
        case (cur)
            S0:      nxt = b ? S1 : S0;
            S1:      nxt = b ? S2 : S0;
            S2:      nxt = b ? S2 : S3;
            S3:      nxt = b ? S4 : S0;
            S4:      nxt = b ? S2 : S0;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

    logic             load_q, clock_q;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic             cur_bit_q, cur_bit_d;
    state_t           state_q, state_d;
    logic             detected_q, detected_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic load_rise_s;
    logic clock_rise_s;
    logic shift_s;

    assign load_rise_s  = load_in & ~load_q;
    assign clock_rise_s = clock_in & ~clock_q;

    // State register: every flop, including the edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_q      <= 1'b0;
            clock_q     <= 1'b0;
            shreg_q     <= {WIDTH{1'b0}};
            bit_idx_q   <= 5'd0;
            cur_bit_q   <= 1'b0;
            state_q     <= S0;
            detected_q  <= 1'b0;
            match_cnt_q <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            load_q      <= load_in;
            clock_q     <= clock_in;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            cur_bit_q   <= cur_bit_d;
            state_q     <= state_d;
            detected_q  <= detected_d;
            match_cnt_q <= match_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: a load rise always wins over a coincident shift.
    always_comb begin
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        cur_bit_d = cur_bit_q;
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = done_q;
        shift_s   = 1'b0;
        if (load_rise_s) begin
            shreg_d   = data_in;
            bit_idx_d = 5'd0;
            cur_bit_d = 1'b0;
            state_d   = S0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
        end else if (clock_rise_s && busy_q) begin
            shift_s   = 1'b1;
            shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            cur_bit_d = shreg_q[WIDTH-1];
            bit_idx_d = bit_idx_q + 5'd1;
            state_d   = fsm_next(state_q, shreg_q[WIDTH-1]);
            if (bit_idx_q == LAST_IDX) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = busy_q;
                done_d = done_q;
            end
        end else begin
            shift_s = 1'b0;
        end
    end

    // Output logic: Moore decode of the next state plus the saturating counter.
    always_comb begin
        detected_d  = (state_d == S4);
        match_cnt_d = match_cnt_q;
        if (load_rise_s) begin
            match_cnt_d = {CNT_W{1'b0}};
        end else if (shift_s && (state_d == S4) && (match_cnt_q != CNT_MAX)) begin
            match_cnt_d = match_cnt_q + CNT_ONE;
        end else begin
            match_cnt_d = match_cnt_q;
        end
    end

    assign cur_bit   = cur_bit_q;
    assign bit_idx   = bit_idx_q;
    assign state     = state_q;
    assign detected  = detected_q;
    assign match_cnt = match_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_detect_1101.sv
// Directed bench for seq_detect_1101 (WIDTH=8, CNT_W=4).
// Outputs are packed as {cur_bit, bit_idx, state, detected, match_cnt, busy, done}
// and compared against hand-computed vectors, sampled 1 ns after each posedge.
module tb_seq_detect_1101;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_in;
    logic       clock_in;
    logic [7:0] data_in;
    logic       cur_bit;
    logic [4:0] bit_idx;
    logic [2:0] state;
    logic       detected;
    logic [3:0] match_cnt;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [15:0] obs;
    assign obs = {cur_bit, bit_idx, state, detected, match_cnt, busy, done};

    seq_detect_1101 #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .load_in(load_in), .clock_in(clock_in),
        .data_in(data_in), .cur_bit(cur_bit), .bit_idx(bit_idx), .state(state),
        .detected(detected), .match_cnt(match_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Pack an expected output vector.
    function automatic logic [15:0] ev(input logic cb, input int idx, input int st,
                                       input logic det, input int mc,
                                       input logic bsy, input logic dn);
        return {cb, 5'(idx), 3'(st), det, 4'(mc), bsy, dn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] d);
        data_in = d;
        load_in = 1'b1;
        tick();
        load_in = 1'b0;
        tick();
    endtask

    task automatic do_shift();
        clock_in = 1'b1;
        tick();
        clock_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] expv;
        reset = 1'b1; load_in = 1'b0; clock_in = 1'b0; data_in = 8'h00;
        tick(); tick();
        expv = 16'h0000;
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL reset_held: got %h want %h", obs, expv); end
        reset = 1'b0;
        tick(); tick();
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL reset_release: got %h want %h", obs, expv); end
        do_shift();
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL idle_shift_ignored: got %h want %h", obs, expv); end
    endtask

    task automatic test_pattern_11011010();
        logic [7:0] bits = 8'b11011010;
        int st_a [8] = '{1, 2, 3, 4, 2, 3, 4, 0};
        int mc_a [8] = '{0, 0, 0, 1, 1, 1, 2, 2};
        logic [15:0] expv;
        do_load(bits);
        expv = ev(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL a_load: got %h want %h", obs, expv); end
        for (int i = 0; i < 8; i++) begin
            do_shift();
            expv = ev(bits[7-i], i + 1, st_a[i], st_a[i] == 4, mc_a[i], i < 7, i == 7);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL a_shift%0d: got %h want %h", i + 1, obs, expv);
            end
        end
    endtask

    task automatic test_all_ones();
        logic [15:0] expv;
        do_load(8'hFF);
        for (int i = 0; i < 8; i++) begin
            do_shift();
            expv = ev(1'b1, i + 1, (i == 0) ? 1 : 2, 1'b0, 0, i < 7, i == 7);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL ones_shift%0d: got %h want %h", i + 1, obs, expv);
            end
        end
    endtask

    task automatic test_pattern_01101101();
        logic [7:0] bits = 8'b01101101;
        int st_a [8] = '{0, 1, 2, 3, 4, 2, 3, 4};
        int mc_a [8] = '{0, 0, 0, 0, 1, 1, 1, 2};
        logic [15:0] expv;
        do_load(bits);
        for (int i = 0; i < 8; i++) begin
            do_shift();
            expv = ev(bits[7-i], i + 1, st_a[i], st_a[i] == 4, mc_a[i], i < 7, i == 7);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL b_shift%0d: got %h want %h", i + 1, obs, expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expv;
        // Continues from the 01101101 frame: done, detected held.
        expv = ev(1'b1, 8, 4, 1'b1, 2, 1'b0, 1'b1);
        do_shift();
        do_shift();
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL after_done_hold: got %h want %h", obs, expv); end
        // Load and clock rise together: load wins.
        data_in = 8'hFF; load_in = 1'b1; clock_in = 1'b1;
        tick();
        expv = ev(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL load_wins: got %h want %h", obs, expv); end
        load_in = 1'b0; clock_in = 1'b0;
        tick();
        do_shift();
        expv = ev(1'b1, 1, 1, 1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL load_wins_shift: got %h want %h", obs, expv); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] expv;
        do_load(8'b10110000);
        do_shift(); do_shift(); do_shift();
        expv = ev(1'b1, 3, 1, 1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL mid_3shifts: got %h want %h", obs, expv); end
        reset = 1'b1;
        tick();
        checks++;
        if (obs !== 16'h0000) begin errors++; $display("FAIL mid_reset: got %h want %h", obs, 16'h0000); end
        // Load held high through reset gives exactly one frame start.
        data_in = 8'b11010000;
        load_in = 1'b1;
        tick(); tick();
        checks++;
        if (obs !== 16'h0000) begin errors++; $display("FAIL load_during_reset: got %h want %h", obs, 16'h0000); end
        reset = 1'b0;
        tick();
        expv = ev(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL load_after_release: got %h want %h", obs, expv); end
        do_shift(); do_shift(); do_shift(); do_shift();
        expv = ev(1'b1, 4, 4, 1'b1, 1, 1'b1, 1'b0);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL held_load_single_start: got %h want %h", obs, expv); end
        load_in = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_pattern_11011010();
        test_all_ones();
        test_pattern_01101101();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
